// File: rtl/pep_mmacc_splitc_sxt_pkg.sv
// Shared types and default sizes for the sample-extract command tracker.
package pep_mmacc_splitc_sxt_pkg;

    localparam int unsigned SXT_CMD_W    = 32;
    localparam int unsigned SXT_CHUNK_W  = 8;
    localparam int unsigned SXT_PEND_MAX = 258;

    typedef struct packed {
        logic [SXT_CMD_W-1:0]   data;
        logic [SXT_CHUNK_W-1:0] chunk_nb;
    } sxt_cmd_t;

endpackage

// File: rtl/pep_mmacc_splitc_sxt_cmd_fifo.sv
// Register FIFO of sample-extract commands with a combinational head read.
module pep_mmacc_splitc_sxt_cmd_fifo
    import pep_mmacc_splitc_sxt_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk_i,
    input  logic                       s_rst_ni,
    input  logic                       wr_en_i,
    input  sxt_cmd_t                   wr_data_i,
    input  logic                       rd_en_i,
    output sxt_cmd_t                   head_o,
    output logic [$clog2(DEPTH+1)-1:0] cnt_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
    sxt_cmd_t       mem_q [DEPTH];

    assign wr_ptr_d = wr_en_i ? wr_ptr_q + (PTR_W+1)'(1) : wr_ptr_q;
    assign rd_ptr_d = rd_en_i ? rd_ptr_q + (PTR_W+1)'(1) : rd_ptr_q;

    always_ff @(posedge clk_i or negedge s_rst_ni) begin
        if (!s_rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= wr_data_i;
        end
    end

    assign head_o = mem_q[rd_ptr_q[PTR_W-1:0]];
    assign cnt_o  = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/pep_mmacc_splitc_sxt_cmd_track.sv
// Matches synchronized chunk-done pulses against queued sample-extract commands and
// releases each command on a valid/ready output once all of its chunks have completed.
module pep_mmacc_splitc_sxt_cmd_track
    import pep_mmacc_splitc_sxt_pkg::*;
#(
    parameter int unsigned CMD_W     = SXT_CMD_W,
    parameter int unsigned CHUNK_W   = SXT_CHUNK_W,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned PEND_MAX  = SXT_PEND_MAX,
    parameter bit          OVF_FATAL = 1'b1
) (
    input  logic                          clk,
    input  logic                          s_rst_n,
    input  logic                          in_cmd_vld,
    output logic                          in_cmd_rdy,
    input  logic [CMD_W-1:0]              in_cmd_data,
    input  logic [CHUNK_W-1:0]            in_cmd_chunk_nb,
    input  logic                          in_chunk_pulse,
    output logic                          out_cmd_vld,
    input  logic                          out_cmd_rdy,
    output logic [CMD_W-1:0]              out_cmd_data,
    output logic [$clog2(DEPTH+1)-1:0]    fifo_cnt,
    output logic [$clog2(PEND_MAX+1)-1:0] pend_cnt,
    output logic                          err_overflow
);

    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned PEND_W = $clog2(PEND_MAX + 1);

    sxt_cmd_t           in_cmd, head;
    logic [CNT_W-1:0]   cnt;
    logic               push, pop, out_free, consumable, avail, consume, last_chunk;
    logic [CHUNK_W-1:0] head_nb;

    logic [CHUNK_W-1:0] chunk_cnt_q, chunk_cnt_d;
    logic [PEND_W-1:0]  pend_cnt_q, pend_cnt_d;
    logic               out_vld_q, out_vld_d;
    logic [CMD_W-1:0]   out_data_q, out_data_d;
    logic               err_q, err_d;

    assign in_cmd = '{data: in_cmd_data, chunk_nb: in_cmd_chunk_nb};

    pep_mmacc_splitc_sxt_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i     (clk),
        .s_rst_ni  (s_rst_n),
        .wr_en_i   (push),
        .wr_data_i (in_cmd),
        .rd_en_i   (pop),
        .head_o    (head),
        .cnt_o     (cnt)
    );

    assign in_cmd_rdy = (cnt < CNT_W'(DEPTH));
    assign push       = in_cmd_vld && in_cmd_rdy;
    assign out_free   = !out_vld_q || out_cmd_rdy;
    assign consumable = (cnt != '0) && out_free;
    assign avail      = in_chunk_pulse || (pend_cnt_q != '0);
    assign consume    = avail && consumable;

    // A zero chunk count is illegal; treat it as a single chunk rather than hang.
    assign head_nb    = (head.chunk_nb == '0) ? CHUNK_W'(1) : head.chunk_nb;
    assign last_chunk = (chunk_cnt_q == head_nb - CHUNK_W'(1));
    assign pop        = consume && last_chunk;

    always_comb begin
        pend_cnt_d  = pend_cnt_q;
        err_d       = err_q;
        chunk_cnt_d = chunk_cnt_q;
        out_vld_d   = out_vld_q;
        out_data_d  = out_data_q;

        // Only the count matters, so a new pulse and a pending one are interchangeable.
        if (in_chunk_pulse && !consume) begin
            if (pend_cnt_q == PEND_W'(PEND_MAX)) begin
                err_d = 1'b1;
            end else begin
                pend_cnt_d = pend_cnt_q + PEND_W'(1);
            end
        end else if (!in_chunk_pulse && consume) begin
            pend_cnt_d = pend_cnt_q - PEND_W'(1);
        end

        if (consume) begin
            chunk_cnt_d = last_chunk ? '0 : chunk_cnt_q + CHUNK_W'(1);
        end

        if (pop) begin
            out_vld_d  = 1'b1;
            out_data_d = head.data;
        end else if (out_cmd_rdy) begin
            out_vld_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            chunk_cnt_q <= '0;
            pend_cnt_q  <= '0;
            out_vld_q   <= 1'b0;
            out_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            chunk_cnt_q <= chunk_cnt_d;
            pend_cnt_q  <= pend_cnt_d;
            out_vld_q   <= out_vld_d;
            out_data_q  <= out_data_d;
            err_q       <= err_d;
        end
    end

    assign out_cmd_vld  = out_vld_q;
    assign out_cmd_data = out_data_q;
    assign fifo_cnt     = cnt;
    assign pend_cnt     = pend_cnt_q;
    assign err_overflow = err_q;

    a_push_rdy: assert property (@(posedge clk) disable iff (!s_rst_n)
        in_cmd_vld |-> in_cmd_rdy)
        else $fatal(1, "command pushed while FIFO full");

    a_nb_zero: assert property (@(posedge clk) disable iff (!s_rst_n)
        push |-> (in_cmd_chunk_nb != '0))
        else $fatal(1, "command pushed with zero chunk count");

    a_ovf: assert property (@(posedge clk) disable iff (!s_rst_n)
        !(OVF_FATAL && err_d && !err_q))
        else $fatal(1, "pending pulse counter overflow");

endmodule

// File: tb/tb_pep_mmacc_splitc_sxt_cmd_track.sv
// Directed table-driven bench for the sample-extract command tracker.
module tb_pep_mmacc_splitc_sxt_cmd_track;

    logic        clk = 1'b0;
    logic        s_rst_n = 1'b0;
    logic        in_cmd_vld = 1'b0;
    logic        in_cmd_rdy;
    logic [31:0] in_cmd_data = '0;
    logic [7:0]  in_cmd_chunk_nb = '0;
    logic        in_chunk_pulse = 1'b0;
    logic        out_cmd_vld;
    logic        out_cmd_rdy = 1'b1;
    logic [31:0] out_cmd_data;
    logic [3:0]  fifo_cnt;
    logic [8:0]  pend_cnt;
    logic        err_overflow;

    int n_checks = 0;
    int n_errs   = 0;

    always #5 clk = ~clk;

    pep_mmacc_splitc_sxt_cmd_track #(
        .CMD_W     (32),
        .CHUNK_W   (8),
        .DEPTH     (8),
        .PEND_MAX  (258),
        .OVF_FATAL (1'b0)
    ) dut (
        .clk             (clk),
        .s_rst_n         (s_rst_n),
        .in_cmd_vld      (in_cmd_vld),
        .in_cmd_rdy      (in_cmd_rdy),
        .in_cmd_data     (in_cmd_data),
        .in_cmd_chunk_nb (in_cmd_chunk_nb),
        .in_chunk_pulse  (in_chunk_pulse),
        .out_cmd_vld     (out_cmd_vld),
        .out_cmd_rdy     (out_cmd_rdy),
        .out_cmd_data    (out_cmd_data),
        .fifo_cnt        (fifo_cnt),
        .pend_cnt        (pend_cnt),
        .err_overflow    (err_overflow)
    );

    typedef struct {
        logic        vld;
        logic [7:0]  nb;
        logic [31:0] data;
        logic        pulse;
        logic        ordy;
        logic        e_vld;
        logic [31:0] e_data;
        int          e_fifo;
        int          e_pend;
        logic        e_irdy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic vld, input logic [7:0] nb, input logic [31:0] data,
                                input logic pulse, input logic ordy, input logic e_vld,
                                input logic [31:0] e_data, input int e_fifo, input int e_pend,
                                input logic e_irdy);
        vec_t v;
        v.vld = vld; v.nb = nb; v.data = data; v.pulse = pulse; v.ordy = ordy;
        v.e_vld = e_vld; v.e_data = e_data; v.e_fifo = e_fifo; v.e_pend = e_pend;
        v.e_irdy = e_irdy;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_all(input string nm, input logic e_vld, input logic [31:0] e_data,
                             input int e_fifo, input int e_pend, input logic e_irdy,
                             input logic e_err);
        chk({nm, " out_cmd_vld"},  64'(out_cmd_vld),  64'(e_vld));
        chk({nm, " out_cmd_data"}, 64'(out_cmd_data), 64'(e_data));
        chk({nm, " fifo_cnt"},     64'(fifo_cnt),     64'(e_fifo));
        chk({nm, " pend_cnt"},     64'(pend_cnt),     64'(e_pend));
        chk({nm, " in_cmd_rdy"},   64'(in_cmd_rdy),   64'(e_irdy));
        chk({nm, " err_overflow"}, 64'(err_overflow), 64'(e_err));
    endtask

    task automatic drive(input logic vld, input logic [7:0] nb, input logic [31:0] data,
                         input logic pulse, input logic ordy);
        in_cmd_vld      = vld;
        in_cmd_chunk_nb = nb;
        in_cmd_data     = data;
        in_chunk_pulse  = pulse;
        out_cmd_rdy     = ordy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // 1) single command, three spaced pulses
        vecs.push_back(mk(1, 3, 32'h11, 0, 1,  0, 32'h00, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0,      0, 1,  0, 32'h00, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0,      1, 1,  0, 32'h00, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0,      0, 1,  0, 32'h00, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0,      1, 1,  0, 32'h00, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0,      0, 1,  0, 32'h00, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0,      1, 1,  1, 32'h11, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0,      0, 1,  0, 32'h11, 0, 0, 1));
        // 2) pulses lead commands
        for (int k = 1; k <= 5; k++) vecs.push_back(mk(0, 0, 0, 1, 1, 0, 32'h11, 0, k, 1));
        vecs.push_back(mk(1, 2, 32'h22, 0, 1,  0, 32'h11, 1, 5, 1));
        vecs.push_back(mk(1, 3, 32'h33, 0, 1,  0, 32'h11, 2, 4, 1));
        vecs.push_back(mk(0, 0, 0,      0, 1,  1, 32'h22, 1, 3, 1));
        vecs.push_back(mk(0, 0, 0,      0, 1,  0, 32'h22, 1, 2, 1));
        vecs.push_back(mk(0, 0, 0,      0, 1,  0, 32'h22, 1, 1, 1));
        vecs.push_back(mk(0, 0, 0,      0, 1,  1, 32'h33, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0,      0, 1,  0, 32'h33, 0, 0, 1));
        // 3) fill FIFO under output stall, then drain back-to-back
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(1, 1, 32'h40 + i, 0, 0, 0, 32'h33, i + 1, 0, (i < 7)));
        vecs.push_back(mk(0, 0, 0, 1, 0, 1, 32'h40, 7, 0, 1));
        for (int k = 2; k <= 10; k++) vecs.push_back(mk(0, 0, 0, 1, 0, 1, 32'h40, 7, k - 1, 1));
        for (int j = 1; j <= 7; j++)
            vecs.push_back(mk(0, 0, 0, 0, 1, 1, 32'h40 + j, 7 - j, 9 - j, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 32'h47, 0, 2, 1));
        // 5) pulse + pending consumed together; push and pop in the same cycle
        vecs.push_back(mk(1, 4, 32'h55, 0, 1,  0, 32'h47, 1, 2, 1));
        vecs.push_back(mk(0, 0, 0,      1, 1,  0, 32'h47, 1, 2, 1));
        vecs.push_back(mk(0, 0, 0,      1, 1,  0, 32'h47, 1, 2, 1));
        vecs.push_back(mk(1, 1, 32'h66, 1, 1,  0, 32'h47, 2, 2, 1));
        vecs.push_back(mk(1, 1, 32'h77, 1, 1,  1, 32'h55, 2, 2, 1));
        vecs.push_back(mk(0, 0, 0,      0, 1,  1, 32'h66, 1, 1, 1));
        vecs.push_back(mk(0, 0, 0,      0, 1,  1, 32'h77, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0,      0, 1,  0, 32'h77, 0, 0, 1));

        #1;
        check_all("rst_init", 0, 32'h0, 0, 0, 1, 0);
        @(posedge clk);
        #3 s_rst_n = 1'b1;
        tick();
        check_all("rst_post", 0, 32'h0, 0, 0, 1, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].vld, vecs[i].nb, vecs[i].data, vecs[i].pulse, vecs[i].ordy);
            tick();
            check_all($sformatf("v%0d", i), vecs[i].e_vld, vecs[i].e_data, vecs[i].e_fifo,
                      vecs[i].e_pend, vecs[i].e_irdy, 1'b0);
        end

        // 4) saturate pending counter with FIFO empty
        drive(0, 0, 0, 1, 1);
        repeat (258) tick();
        check_all("ovf_fill", 0, 32'h77, 0, 258, 1, 0);
        tick();
        check_all("ovf_drop", 0, 32'h77, 0, 258, 1, 1);
        drive(0, 0, 0, 0, 1);
        tick();
        check_all("ovf_sticky", 0, 32'h77, 0, 258, 1, 1);

        // 6) asynchronous reset in the middle of a command (chunk_cnt = 2)
        drive(1, 4, 32'h99, 0, 1);
        tick();
        check_all("mid_push", 0, 32'h77, 1, 258, 1, 1);
        drive(0, 0, 0, 0, 1);
        tick();
        check_all("mid_c1", 0, 32'h77, 1, 257, 1, 1);
        tick();
        check_all("mid_c2", 0, 32'h77, 1, 256, 1, 1);
        #2 s_rst_n = 1'b0;
        #1;
        check_all("rst_async", 0, 32'h0, 0, 0, 1, 0);
        tick();
        #3 s_rst_n = 1'b1;
        tick();
        check_all("rst_release", 0, 32'h0, 0, 0, 1, 0);

        // chunk counter must restart from zero after reset
        drive(1, 3, 32'hAA, 0, 1);
        tick();
        check_all("post_push", 0, 32'h0, 1, 0, 1, 0);
        drive(0, 0, 0, 1, 1);
        tick();
        check_all("post_p1", 0, 32'h0, 1, 0, 1, 0);
        tick();
        check_all("post_p2", 0, 32'h0, 1, 0, 1, 0);
        tick();
        check_all("post_p3", 1, 32'hAA, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 1);
        tick();
        check_all("post_fire", 0, 32'hAA, 0, 0, 1, 0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
